// File: rtl/sig_divider_pkg.sv
// Shared types and sizing helpers for the sig_divider restoring divider.
package sig_divider_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } divState_t;

    localparam int FRACW_DEFAULT = 23;

    // Bits needed to count down from width to zero.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sig_divider_div_step.sv
// One combinational radix-2 restoring step: shift in the next dividend bit,
// trial-subtract the divisor, and keep the difference only if it is non-negative.
module sig_divider_div_step #(
    parameter int WIDTH = 24
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             bitIn,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] newRem,
    output logic             qBit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    always_comb begin
        shifted = {rem, bitIn};
        trial   = shifted - {1'b0, divisor};
        // The incoming remainder is below the divisor, so the trial fits in
        // WIDTH+1 bits and its MSB is a reliable sign bit.
        qBit    = ~trial[WIDTH];
        newRem  = qBit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/sig_divider.sv
// Iterative radix-2 restoring unsigned divider, one quotient bit per clock.
// Optional SIG_DIVIDER_ZERO_BYPASS_EN: a zero divisor skips the iterations.
module sig_divider
    import sig_divider_pkg::*;
#(
    parameter int FRACW = FRACW_DEFAULT,
    parameter int WIDTH = FRACW + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] divIn1,
    input  logic [WIDTH-1:0] divIn2,
    output logic [WIDTH-1:0] quotOut,
    output logic [WIDTH-1:0] remOut,
    output logic             divByZero,
    output logic             done
);

    localparam int CW = cnt_width(WIDTH);

    divState_t        state, state_nx;
    logic [WIDTH-1:0] rem_q, rem_nx;
    logic [WIDTH-1:0] qreg_q, qreg_nx;
    logic [WIDTH-1:0] dvsr_q, dvsr_nx;
    logic [CW-1:0]    cnt_q, cnt_nx;
    logic             dz_q, dz_nx;
    logic [WIDTH-1:0] quot_nx, remo_nx;
    logic             dbz_nx, done_nx;
    logic [WIDTH-1:0] step_rem;
    logic             step_qbit;
    logic             accept;

    sig_divider_div_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem_q),
        .bitIn   (qreg_q[WIDTH-1]),
        .divisor (dvsr_q),
        .newRem  (step_rem),
        .qBit    (step_qbit)
    );

    // In DONE a new request is taken only once the result has been presented.
    assign accept = start && ((state == IDLE) || ((state == DONE) && done));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned; that is what keeps latches from being inferred.
        state_nx = state;
        rem_nx   = rem_q;
        qreg_nx  = qreg_q;
        dvsr_nx  = dvsr_q;
        cnt_nx   = cnt_q;
        dz_nx    = dz_q;
        quot_nx  = quotOut;
        remo_nx  = remOut;
        dbz_nx   = divByZero;
        done_nx  = done;

        if (accept) begin
            dvsr_nx  = divIn2;
            qreg_nx  = divIn1;
            rem_nx   = '0;
            cnt_nx   = CW'(WIDTH);
            dz_nx    = (divIn2 == '0);
            done_nx  = 1'b0;
            state_nx = CALC;
`ifdef SIG_DIVIDER_ZERO_BYPASS_EN
            if (divIn2 == '0) begin
                // Same values the iterations would have produced.
                qreg_nx  = '1;
                rem_nx   = divIn1;
                cnt_nx   = '0;
                state_nx = DONE;
            end
`endif
        end else begin
            case (state)
                CALC: begin
                    rem_nx  = step_rem;
                    qreg_nx = {qreg_q[WIDTH-2:0], step_qbit};
                    cnt_nx  = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_nx = DONE;
                    end
                end
                DONE: begin
                    if (!done) begin
                        quot_nx = qreg_q;
                        remo_nx = rem_q;
                        dbz_nx  = dz_q;
                        done_nx = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            rem_q     <= '0;
            qreg_q    <= '0;
            dvsr_q    <= '0;
            cnt_q     <= '0;
            dz_q      <= 1'b0;
            quotOut   <= '0;
            remOut    <= '0;
            divByZero <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            rem_q     <= rem_nx;
            qreg_q    <= qreg_nx;
            dvsr_q    <= dvsr_nx;
            cnt_q     <= cnt_nx;
            dz_q      <= dz_nx;
            quotOut   <= quot_nx;
            remOut    <= remo_nx;
            divByZero <= dbz_nx;
            done      <= done_nx;
        end
    end

endmodule

// File: tb/tb_sig_divider.sv
// Self-checking bench for sig_divider: directed vector table, multi-cycle
// corner sequences (mid-run reset, back-to-back start) and random pairs.
module tb_sig_divider;
    import sig_divider_pkg::*;

    localparam int FRACW   = 23;
    localparam int W       = FRACW + 1;
    localparam int TIMEOUT = 200;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] divIn1, divIn2;
    logic [W-1:0] quotOut, remOut;
    logic         divByZero, done;

    int n_checks = 0;
    int n_errors = 0;

    sig_divider #(.FRACW(FRACW)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .divIn1    (divIn1),
        .divIn2    (divIn2),
        .quotOut   (quotOut),
        .remOut    (remOut),
        .divByZero (divByZero),
        .done      (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic dz);
`ifdef SIG_DIVIDER_ZERO_BYPASS_EN
        return dz ? 1 : W + 1;
`else
        return (dz === 1'bx) ? 0 : W + 1;
`endif
    endfunction

    // Wait for done after an accepting edge; counts edges past that edge.
    task automatic wait_done(input bit pulse_mid, output int lat);
        lat = 0;
        while (!done && lat < TIMEOUT) begin
            @(posedge clock); #1;
            lat++;
            start = pulse_mid && (lat == 5);
            if (start) begin
                divIn1 = 24'd9;
                divIn2 = 24'd2;
            end
        end
        start = 1'b0;
        if (!done) check("done_timeout", {63'd0, done}, 64'd1);
    endtask

    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit pulse_mid, output int lat);
        @(negedge clock);
        start  = 1'b1;
        divIn1 = a;
        divIn2 = b;
        @(posedge clock); #1;
        start  = 1'b0;
        divIn1 = W'($urandom);
        divIn2 = W'($urandom);
        wait_done(pulse_mid, lat);
    endtask

    initial begin
        int lat;
        logic [W-1:0] ra, rb;

        vecs[0]  = '{24'd100,      24'd7,       24'd14,      24'd2,       1'b0};
        vecs[1]  = '{24'hFFFFFF,   24'd1,       24'hFFFFFF,  24'd0,       1'b0};
        vecs[2]  = '{24'd5,        24'd9,       24'd0,       24'd5,       1'b0};
        vecs[3]  = '{24'd1234,     24'd0,       24'hFFFFFF,  24'd1234,    1'b1};
        vecs[4]  = '{24'd1000,     24'd3,       24'd333,     24'd1,       1'b0};
        vecs[5]  = '{24'd0,        24'd5,       24'd0,       24'd0,       1'b0};
        vecs[6]  = '{24'hFFFFFF,   24'hFFFFFF,  24'd1,       24'd0,       1'b0};
        vecs[7]  = '{24'd123456,   24'd1000,    24'd123,     24'd456,     1'b0};
        vecs[8]  = '{24'h800000,   24'd2,       24'h400000,  24'd0,       1'b0};
        vecs[9]  = '{24'hFFFFFF,   24'h001000,  24'h000FFF,  24'h000FFF,  1'b0};
        vecs[10] = '{24'd7,        24'd7,       24'd1,       24'd0,       1'b0};

        reset  = 1'b1;
        start  = 1'b1;
        divIn1 = 24'd100;
        divIn2 = 24'd7;
        repeat (3) @(posedge clock);
        #1;
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_quot", quotOut, 64'd0);
        check("reset_rem", remOut, 64'd0);
        check("reset_dbz", {63'd0, divByZero}, 64'd0);
        start = 1'b0;
        reset = 1'b0;

        // Directed table; vector 0 also gets a start pulse mid-CALC.
        for (int i = 0; i < 11; i++) begin
            run_div(vecs[i].a, vecs[i].b, (i == 0), lat);
            check($sformatf("vec%0d_quot", i), quotOut, vecs[i].q);
            check($sformatf("vec%0d_rem", i), remOut, vecs[i].r);
            check($sformatf("vec%0d_dbz", i), {63'd0, divByZero}, {63'd0, vecs[i].dz});
            check($sformatf("vec%0d_latency", i), lat, exp_lat(vecs[i].dz));
        end

        // Reset ten cycles into CALC, with a non-zero prior result on the outputs.
        @(negedge clock);
        start  = 1'b1;
        divIn1 = 24'd100;
        divIn2 = 24'd7;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("midreset_done", {63'd0, done}, 64'd0);
        check("midreset_quot", quotOut, 64'd0);
        check("midreset_rem", remOut, 64'd0);
        check("midreset_dbz", {63'd0, divByZero}, 64'd0);
        run_div(24'd200, 24'd9, 1'b0, lat);
        check("postreset_quot", quotOut, 64'd22);
        check("postreset_rem", remOut, 64'd2);
        check("postreset_latency", lat, W + 1);

        // Back-to-back: start held high from the first accept through DONE.
        @(negedge clock);
        start  = 1'b1;
        divIn1 = 24'd100;
        divIn2 = 24'd7;
        @(posedge clock); #1;
        divIn1 = 24'd1000;
        divIn2 = 24'd3;
        lat = 0;
        while (!done && lat < TIMEOUT) begin
            @(posedge clock); #1;
            lat++;
        end
        check("b2b_first_latency", lat, W + 1);
        check("b2b_first_quot", quotOut, 64'd14);
        check("b2b_first_rem", remOut, 64'd2);
        @(posedge clock); #1;
        check("b2b_done_drop", {63'd0, done}, 64'd0);
        start  = 1'b0;
        divIn1 = W'($urandom);
        divIn2 = W'($urandom);
        wait_done(1'b0, lat);
        check("b2b_second_latency", lat, W + 1);
        check("b2b_second_quot", quotOut, 64'd333);
        check("b2b_second_rem", remOut, 64'd1);

        // Random pairs against a division model, mixing wide and narrow divisors.
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (i % 2 == 1) rb = rb >> $urandom_range(0, W - 1);
            if (rb == '0) rb = W'(1);
            run_div(ra, rb, 1'b0, lat);
            check($sformatf("rand%0d_quot(%0d/%0d)", i, ra, rb), quotOut, ra / rb);
            check($sformatf("rand%0d_rem(%0d/%0d)", i, ra, rb), remOut, ra % rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
